si7021_data_converter: RTL and testbench
========================================

Name: si7021_data_converter

Overview:
Downstream of the I2C master. Takes the raw 16-bit Si7021 measurement word (temperature or relative-humidity code) and converts it to a signed value in hundredths of a unit (°C or %RH). Emits the result as a sign flag plus five BCD digits for the display/UART stage. Uses a sequential shift-add multiplier and an iterative double-dabble, so there are no wide combinational multipliers.

Parameters:
TEMP_GAIN, 17572, temperature scale (175.72 × 100), unsigned 15-bit
TEMP_OFFSET, 4685, temperature offset (46.85 × 100)
RH_GAIN, 12500, humidity scale (125 × 100)
RH_OFFSET, 600, humidity offset (6 × 100)
RH_MAX, 10000, humidity upper clamp (100.00 %)

Ports:
clk100MHz  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
data_in  in  16  raw measurement word, MSB byte first as delivered by the I2C master
meas_type  in  1  0 = temperature code, 1 = RH code; sampled with data_valid
data_valid  in  1  one-cycle strobe, data_in/meas_type valid
busy  out  1  high from the accepting edge until result_valid
result_valid  out  1  one-cycle pulse, result outputs updated
result_neg  out  1  result is negative (temperature only)
result_bcd  out  20  five BCD digits of |result| in hundredths, [19:16] most significant
result_is_rh  out  1  meas_type of the current result
overrun  out  1  sticky: a data_valid arrived while busy

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - All outputs 0; internal accumulators 0.
  - Takes effect mid-conversion: the partial result is discarded and no result_valid is issued.
- Input capture: in IDLE, when data_valid=1, latch code = {data_in[15:2], 2'b00}. Bits [1:0] are Si7021 status bits and are always masked. Also latch meas_type, set busy, go to MULT.
- MULT: 16 cycles of shift-add, code LSB first, on 31-bit product = gain × code. Gain is TEMP_GAIN or RH_GAIN by the latched type. Then go to OFFSET.
- OFFSET (1 cycle), using scaled = product[30:16], zero-extended to a 17-bit signed value:
  - Temperature: value = scaled − TEMP_OFFSET. neg = value<0; mag = |value|.
  - RH: value = scaled − RH_OFFSET. Clamp to [0, RH_MAX]; neg = 0.
  - mag is guaranteed ≤ 12887 and is carried as 14 bits.
- BCD: 14 cycles of double-dabble on the 14-bit mag into a 20-bit BCD register. Each cycle: add 3 to every digit ≥ 5, then shift left one, inserting the mag MSB.
- DONE (1 cycle):
  - Register result_bcd, result_neg and result_is_rh.
  - Pulse result_valid; clear busy; return to IDLE.
- Latency: result_valid is high in the cycle following the 32nd rising edge after the edge that sampled data_valid (1 capture + 16 MULT + 1 OFFSET + 14 BCD). Fixed, independent of data.
- Back-to-back: data_valid during busy (including the DONE cycle) is ignored and sets overrun. overrun clears only on reset.
- data_valid in the cycle right after the result_valid pulse (FSM in IDLE) is accepted normally.
- Result outputs hold their value until the next DONE. result_valid is never high for two consecutive cycles.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, MULT, OFFSET, BCD, DONE).
  - The gain/offset/clamp constants above.
  - MEAS_TEMP=0 / MEAS_RH=1.
  - Widths: PROD_W=31, MAG_W=14, BCD_W=20.
- One natural sub-module: bin2bcd_seq, an iterative double-dabble with a start/done handshake, MAG_W-cycle latency, and parameterised MAG_W/BCD_W. The converter FSM instantiates it for the BCD phase.

Test Plan:
- Temp data_in=0x6640 → result_valid 32 cycles after strobe; neg=0, bcd=0x02333 (23.33 °C); busy high exactly those 32 cycles.
- Temp data_in=0x0000 → neg=1, bcd=0x04685. Temp 0xFFFF (masked to 0xFFFC) → neg=0, bcd=0x12885.
- RH data_in=0x8000 → bcd=0x05650. RH 0x0000 → bcd=0x00000 (low clamp). RH 0xFFFF → bcd=0x10000 (high clamp); result_is_rh=1 throughout.
- Strobe 0x6640 (temp), then a second strobe 5 cycles later → single result 0x02333, overrun=1. A new strobe 1 cycle after result_valid → accepted, correct result.
- Assert rst_n=0 at MULT cycle 8 then release → no result_valid; all outputs 0. The next strobe converts correctly.
- Status bits: temp 0x6643 → identical to 0x6640 (bcd=0x02333).

Source files
------------

// File: rtl/si7021_data_converter_pkg.sv
// rtl/si7021_data_converter_pkg.sv - shared states, widths and scaling constants for the Si7021 converter
package si7021_data_converter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    OFFSET,
    BCD,
    DONE
  } state_t;

  localparam int PROD_W = 31;
  localparam int MAG_W  = 14;
  localparam int BCD_W  = 20;

  localparam logic MEAS_TEMP = 1'b0;
  localparam logic MEAS_RH   = 1'b1;

  localparam logic [14:0]        TEMP_GAIN   = 15'd17572;
  localparam logic [14:0]        RH_GAIN     = 15'd12500;
  localparam logic signed [16:0] TEMP_OFFSET = 17'sd4685;
  localparam logic signed [16:0] RH_OFFSET   = 17'sd600;
  localparam logic signed [16:0] RH_MAX      = 17'sd10000;

endpackage

// File: rtl/si7021_data_converter_bin2bcd.sv
// rtl/si7021_data_converter_bin2bcd.sv - iterative double-dabble, MAG_W cycles from start to done
module bin2bcd_seq
  import si7021_data_converter_pkg::*;
#(
  parameter int MAG_W_P = MAG_W,
  parameter int BCD_W_P = BCD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAG_W_P-1:0] mag,
  output logic               done,
  output logic [BCD_W_P-1:0] bcd
);

  localparam int CNT_W = $clog2(MAG_W_P + 1);

  logic [MAG_W_P-1:0] sreg;
  logic [BCD_W_P-1:0] acc_adj;
  logic [CNT_W-1:0]   cnt;
  logic               unused_msb;

  assign unused_msb = acc_adj[BCD_W_P-1];

  always_comb begin
    acc_adj = bcd;
    for (int i = 0; i < BCD_W_P / 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // The load edge doubles as the first iteration: add-3 on an all-zero BCD is a no-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      bcd  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd  <= {{(BCD_W_P-1){1'b0}}, mag[MAG_W_P-1]};
        sreg <= mag << 1;
        cnt  <= CNT_W'(MAG_W_P - 1);
      end else if (cnt != '0) begin
        bcd  <= {acc_adj[BCD_W_P-2:0], sreg[MAG_W_P-1]};
        sreg <= sreg << 1;
        cnt  <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/si7021_data_converter.sv
// rtl/si7021_data_converter.sv - Si7021 raw code to signed hundredths, emitted as sign + five BCD digits
module si7021_data_converter
  import si7021_data_converter_pkg::*;
(
  input  logic        clk100MHz,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        meas_type,
  input  logic        data_valid,
  output logic        busy,
  output logic        result_valid,
  output logic        result_neg,
  output logic [19:0] result_bcd,
  output logic        result_is_rh,
  output logic        overrun
);

  state_t              state, state_next;
  logic [3:0]          mult_cnt;
  logic [PROD_W-1:0]   product;
  logic [PROD_W-1:0]   mcand;
  logic [15:0]         mplier;
  logic                is_rh;
  logic                neg;
  logic                start_bcd;
  logic                bcd_done;
  logic [BCD_W-1:0]    bcd_val;
  logic [MAG_W-1:0]    mag;
  logic                mag_neg;
  logic signed [16:0]  offset;
  logic signed [16:0]  value;
  logic signed [16:0]  value_abs;
  logic                unused_bits;

  assign unused_bits = ^{product[15:0], value_abs[16:MAG_W]};

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_bcd  = 1'b0;
    case (state)
      IDLE:    if (data_valid) state_next = MULT;
      MULT:    if (mult_cnt == 4'd15) state_next = OFFSET;
      OFFSET:  begin
        start_bcd  = 1'b1;
        state_next = BCD;
      end
      BCD:     if (bcd_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Upper 15 product bits are the scaled value; it is never negative before the offset.
  always_comb begin
    offset    = (is_rh == MEAS_RH) ? RH_OFFSET : TEMP_OFFSET;
    value     = $signed({2'b00, product[PROD_W-1:16]}) - offset;
    value_abs = value[16] ? -value : value;
    mag       = value_abs[MAG_W-1:0];
    mag_neg   = 1'b0;
    if (is_rh == MEAS_RH) begin
      if (value < 17'sd0)       mag = '0;
      else if (value > RH_MAX)  mag = RH_MAX[MAG_W-1:0];
    end else begin
      mag_neg = value[16];
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      mult_cnt     <= '0;
      product      <= '0;
      mcand        <= '0;
      mplier       <= '0;
      is_rh        <= 1'b0;
      neg          <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_neg   <= 1'b0;
      result_bcd   <= '0;
      result_is_rh <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (data_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (data_valid) begin
            mplier   <= {data_in[15:2], 2'b00};
            mcand    <= {16'b0, (meas_type == MEAS_RH) ? RH_GAIN : TEMP_GAIN};
            product  <= '0;
            mult_cnt <= '0;
            is_rh    <= meas_type;
            busy     <= 1'b1;
          end
        end
        MULT: begin
          if (mplier[0]) product <= product + mcand;
          mcand    <= mcand << 1;
          mplier   <= mplier >> 1;
          mult_cnt <= mult_cnt + 4'd1;
        end
        OFFSET: neg <= mag_neg;
        DONE: begin
          result_bcd   <= bcd_val;
          result_neg   <= neg;
          result_is_rh <= is_rh;
          result_valid <= 1'b1;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  bin2bcd_seq #(
    .MAG_W_P(MAG_W),
    .BCD_W_P(BCD_W)
  ) u_bin2bcd (
    .clk  (clk100MHz),
    .rst_n(rst_n),
    .start(start_bcd),
    .mag  (mag),
    .done (bcd_done),
    .bcd  (bcd_val)
  );

endmodule

// File: tb/tb_si7021_data_converter.sv
// tb/tb_si7021_data_converter.sv - self-checking bench for si7021_data_converter
module tb_si7021_data_converter;

  logic        clk100MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        meas_type = 1'b0;
  logic        data_valid = 1'b0;
  logic        busy, result_valid, result_neg, result_is_rh, overrun;
  logic [19:0] result_bcd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk100MHz = ~clk100MHz;

  si7021_data_converter dut (
    .clk100MHz   (clk100MHz),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .meas_type   (meas_type),
    .data_valid  (data_valid),
    .busy        (busy),
    .result_valid(result_valid),
    .result_neg  (result_neg),
    .result_bcd  (result_bcd),
    .result_is_rh(result_is_rh),
    .overrun     (overrun)
  );

  // Reference: real-number conversion done with integer arithmetic, then decimal digit extraction.
  function automatic void model(input logic [15:0] d, input logic t,
                                output logic neg, output logic [19:0] bcd);
    longint code, v;
    code = longint'({d[15:2], 2'b00});
    if (!t) begin
      v = (17572 * code) / 65536 - 4685;
    end else begin
      v = (12500 * code) / 65536 - 600;
      if (v < 0) v = 0;
      if (v > 10000) v = 10000;
    end
    neg = (v < 0);
    if (v < 0) v = -v;
    bcd = '0;
    for (int i = 0; i < 5; i++) begin
      bcd[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  task automatic run_conv(input logic [15:0] d, input logic t, output int lat, output int busy_cyc);
    @(negedge clk100MHz);
    data_in = d; meas_type = t; data_valid = 1'b1;
    @(negedge clk100MHz);
    data_valid = 1'b0;
    data_in = 16'($urandom);
    lat = -1; busy_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid) begin
        lat = k;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk100MHz);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk100MHz);
    vectors++;
    if ({busy, result_valid, result_neg, result_bcd, result_is_rh, overrun} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {busy, result_valid, result_neg, result_bcd, result_is_rh, overrun});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk100MHz);
    vectors++;
    if ({busy, result_valid, overrun} !== 3'b000) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b want 000", {busy, result_valid, overrun});
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        t;
    logic        neg;
    logic [19:0] bcd;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[8];
    int lat, bc;
    logic [19:0] held;
    tbl[0] = '{16'h6640, 1'b0, 1'b0, 20'h02333};
    tbl[1] = '{16'h0000, 1'b0, 1'b1, 20'h04685};
    tbl[2] = '{16'hFFFF, 1'b0, 1'b0, 20'h12885};
    tbl[3] = '{16'h8000, 1'b1, 1'b0, 20'h05650};
    tbl[4] = '{16'h0000, 1'b1, 1'b0, 20'h00000};
    tbl[5] = '{16'hFFFF, 1'b1, 1'b0, 20'h10000};
    tbl[6] = '{16'h6643, 1'b0, 1'b0, 20'h02333};
    tbl[7] = '{16'h8003, 1'b1, 1'b0, 20'h05650};
    foreach (tbl[i]) begin
      run_conv(tbl[i].d, tbl[i].t, lat, bc);
      vectors++;
      if (lat !== 32) begin
        miscompares++;
        $display("FAIL dir_latency[%0d]: got %0d want 32", i, lat);
      end
      vectors++;
      if (bc !== 32 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL dir_busy[%0d]: got cycles=%0d busy=%b want 32/0", i, bc, busy);
      end
      vectors++;
      if (result_neg !== tbl[i].neg || result_bcd !== tbl[i].bcd || result_is_rh !== tbl[i].t) begin
        miscompares++;
        $display("FAIL dir_result[%0d]: got neg=%b bcd=%h rh=%b want neg=%b bcd=%h rh=%b",
                 i, result_neg, result_bcd, result_is_rh, tbl[i].neg, tbl[i].bcd, tbl[i].t);
      end
      held = result_bcd;
      @(negedge clk100MHz);
      vectors++;
      if (result_valid !== 1'b0 || result_bcd !== tbl[i].bcd || held !== tbl[i].bcd) begin
        miscompares++;
        $display("FAIL dir_pulse_hold[%0d]: got valid=%b bcd=%h want 0/%h", i, result_valid, result_bcd, tbl[i].bcd);
      end
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [15:0] d;
    logic t, eneg;
    logic [19:0] ebcd;
    for (int n = 0; n < 24; n++) begin
      d = 16'($urandom);
      t = 1'($urandom_range(0, 1));
      model(d, t, eneg, ebcd);
      run_conv(d, t, lat, bc);
      vectors++;
      if (lat !== 32 || result_neg !== eneg || result_bcd !== ebcd || result_is_rh !== t || overrun !== 1'b0) begin
        miscompares++;
        $display("FAIL rand[%0d] d=%h t=%b: got lat=%0d neg=%b bcd=%h rh=%b ovr=%b want 32/%b/%h/%b/0",
                 n, d, t, lat, result_neg, result_bcd, result_is_rh, overrun, eneg, ebcd, t);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, pulses;
    @(negedge clk100MHz);
    data_in = 16'h6640; meas_type = 1'b0; data_valid = 1'b1;
    @(negedge clk100MHz);
    data_valid = 1'b0;
    repeat (4) @(negedge clk100MHz);
    data_in = 16'h0000; meas_type = 1'b1; data_valid = 1'b1;
    @(negedge clk100MHz);
    data_valid = 1'b0;
    pulses = 0; lat = -1;
    for (int k = 5; k < 45; k++) begin
      if (result_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          vectors++;
          if (result_bcd !== 20'h02333 || result_neg !== 1'b0 || result_is_rh !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_result: got bcd=%h neg=%b rh=%b want 02333/0/0", result_bcd, result_neg, result_is_rh);
          end
        end
      end
      if (lat >= 0) break;
      @(negedge clk100MHz);
    end
    vectors++;
    if (lat !== 32 || pulses !== 1 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_single: got lat=%0d pulses=%0d overrun=%b want 32/1/1", lat, pulses, overrun);
    end
    run_conv(16'h8000, 1'b1, lat, bc);
    vectors++;
    if (lat !== 32 || result_bcd !== 20'h05650 || result_is_rh !== 1'b1 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_follow: got lat=%0d bcd=%h rh=%b ovr=%b want 32/05650/1/1", lat, result_bcd, result_is_rh, overrun);
    end
  endtask

  task automatic test_mid_reset();
    int lat, bc, pulses;
    @(negedge clk100MHz);
    data_in = 16'h6640; meas_type = 1'b0; data_valid = 1'b1;
    @(negedge clk100MHz);
    data_valid = 1'b0;
    repeat (8) @(negedge clk100MHz);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, result_valid, result_neg, result_bcd, result_is_rh, overrun} !== 25'd0) begin
      miscompares++;
      $display("FAIL midreset_async: got %h want 0", {busy, result_valid, result_neg, result_bcd, result_is_rh, overrun});
    end
    @(negedge clk100MHz);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid) pulses++;
      @(negedge clk100MHz);
    end
    vectors++;
    if (pulses !== 0 || {busy, result_neg, result_bcd, result_is_rh, overrun} !== 24'd0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got pulses=%0d outs=%h want 0/0", pulses, {busy, result_neg, result_bcd, result_is_rh, overrun});
    end
    run_conv(16'h6640, 1'b0, lat, bc);
    vectors++;
    if (lat !== 32 || result_bcd !== 20'h02333 || result_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_recover: got lat=%0d bcd=%h neg=%b want 32/02333/0", lat, result_bcd, result_neg);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
